draw_sequencer: RTL
===================

# draw_sequencer

Frame-level scheduler for the shared pixel writer. On each frame `start` it erases every object's previously drawn box, then draws every requested object's new box in ascending index order. It emits one framebuffer write (x, y, color) per clock. It sits between the game-object logic (bird, pipes, TV sprite) and the framebuffer write port, serialising all rectangle fills onto one pixel stream.

## Interface
Parameters:
- `N_OBJ`, 4: number of requesting objects
- `CW`, 1: pixel color width
- `SCR_W`, 640: screen width; pixels with x ≥ SCR_W are suppressed
- `SCR_H`, 480: screen height; pixels with y ≥ SCR_H are suppressed
- `BG`, 0: erase color

Ports:
- `clkf`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `start`  in  1  frame trigger, sampled only in IDLE
- `req`  in  N_OBJ  per-object draw request for this frame
- `llx`, `lly`  in  N_OBJ×11  per-object lower-left corner
- `trx`, `try`  in  N_OBJ×11  per-object top-right corner, inclusive
- `color`  in  N_OBJ×CW  per-object fill color
- `x`, `y`  out  11  current pixel address
- `pix_color`  out  CW  current pixel color
- `pix_we`  out  1  write strobe for (x, y, pix_color)
- `grant`  out  N_OBJ  one-hot owner of the current pixel; 0 when not scanning
- `busy`  out  1  high from the cycle after `start` acceptance until DONE inclusive
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, SELECT, SCAN, DONE. A `phase` bit selects ERASE or DRAW.
- IDLE, `start`=1 at a clock edge:
  - snapshot `req`, boxes and `color` into registers
  - set phase=ERASE
  - mark pending-erase = `old_valid`, pending-draw = snapshot `req`
  - go to SELECT
- SELECT performs exactly one action per cycle:
  - lowest-index pending object in the current phase, non-degenerate box: load x=llx, y=lly, go to SCAN.
  - lowest pending box is degenerate (trx<llx or try<lly, unsigned compare): clear its pending bit, stay in SELECT. It writes no pixels.
  - ERASE phase, nothing pending: switch phase to DRAW, stay in SELECT.
  - DRAW phase, nothing pending: go to DONE.
- ERASE uses the stored old box and color=BG. DRAW uses the snapshot box and its color.
- SCAN is column-major, one pixel per cycle:
  - y increments from lly to try.
  - at y==try with x<trx: set y=lly and increment x.
  - at x==trx and y==try: clear the pending bit, return to SELECT.
- Old-box bookkeeping:
  - completing the DRAW of object i stores its snapshot box as old box i and sets `old_valid[i]`.
  - entering DRAW phase clears `old_valid[i]` for every i with snapshot `req[i]`=0.
  - a degenerate drawn box sets `old_valid[i]`=0.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored; it is not queued.
- Reset mid-frame: state returns to IDLE, all outputs go to reset values, and `old_valid` clears. The next frame erases nothing.

## Timing
- Reset values: x=0, y=0, pix_color=0, pix_we=0, grant=0, busy=0, done=0, old_valid=0.
- All outputs are registered.
- `pix_we`=1 exactly in SCAN cycles whose (x, y) satisfy x<SCR_W and y<SCR_H. x and y still advance through clipped pixels.
- `pix_we`=0 in IDLE, SELECT and DONE.
- Object pixel count is (trx−llx+1)·(try−lly+1), in that many consecutive SCAN cycles.
- Cycle count, with `start` accepted at edge T0:
  - one SELECT cycle per object retired or per phase switch, plus SCAN cycles, plus one DONE cycle
  - empty frame: SELECT T1, SELECT T2, DONE T3, IDLE T4
- Inputs may change freely after the accepting edge. Only the snapshot is used.

## Structure
- Package `draw_seq_pkg`:
  - `state_t` enum {IDLE, SELECT, SCAN, DONE}
  - `phase_t` enum {ERASE, DRAW}
  - `box_t` struct {llx, lly, trx, try}, each logic [10:0]
  - `COORD_W`=11
- Sub-module `rect_scanner`:
  - load/advance inputs
  - x/y walker with a `last` flag
  - instantiated once, shared by both phases
- The top level holds the FSM, the priority picker, the snapshot registers and the old-box registers.

## Test plan
- Empty frame: `req`=0 at reset state, `start` pulse → SELECT, SELECT, DONE; `done` at T3; zero `pix_we` cycles.
- First frame, obj0 box (10,20)-(11,22), color=1 → T1 SELECT/ERASE, T2 SELECT; T3–T8 `pix_we`=1 with (10,20), (10,21), (10,22), (11,20), (11,21), (11,22); `grant`=0001; `done` at T10.
- Second frame, obj0 moved to (12,20)-(12,20) → erase six pixels of the old box with color 0, then draw one pixel (12,20) with color 1; erase strictly precedes draw.
- Two objects (obj1 2×1, obj3 1×1) plus degenerate obj2 (trx<llx) → draw order obj1, then obj3; obj2 costs one SELECT cycle and writes nothing; `grant` is 0010 then 1000.
- Clipping: box (638,0)-(641,0) → 4 SCAN cycles; `pix_we`=1 only for x=638 and x=639.
- Reset asserted during SCAN, then a new `start` → outputs zero the cycle after reset; the next frame performs no erase.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared types for the frame draw sequencer: FSM states, erase/draw phase and box geometry.
package draw_seq_pkg;

  localparam int unsigned COORD_W = 11;

  typedef enum logic [1:0] {IDLE, SELECT, SCAN, DONE} state_t;
  typedef enum logic {ERASE, DRAW} phase_t;

  typedef struct packed {
    logic [COORD_W-1:0] llx;
    logic [COORD_W-1:0] lly;
    logic [COORD_W-1:0] trx;
    logic [COORD_W-1:0] try;
  } box_t;

  // A box with an inverted edge covers no pixels.
  function automatic logic box_degenerate(input box_t b);
    return (b.trx < b.llx) || (b.try < b.lly);
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Object-request / pixel-stream bundle between the game-object logic and the draw sequencer.
interface draw_seq_if #(
  parameter int unsigned N_OBJ = 4,
  parameter int unsigned CW    = 1
);
  logic                                               start;
  logic [N_OBJ-1:0]                                   req;
  logic [N_OBJ-1:0][draw_seq_pkg::COORD_W-1:0]        llx;
  logic [N_OBJ-1:0][draw_seq_pkg::COORD_W-1:0]        lly;
  logic [N_OBJ-1:0][draw_seq_pkg::COORD_W-1:0]        trx;
  logic [N_OBJ-1:0][draw_seq_pkg::COORD_W-1:0]        try;
  logic [N_OBJ-1:0][CW-1:0]                           color;
  logic [draw_seq_pkg::COORD_W-1:0]                   x;
  logic [draw_seq_pkg::COORD_W-1:0]                   y;
  logic [CW-1:0]                                      pix_color;
  logic                                               pix_we;
  logic [N_OBJ-1:0]                                   grant;
  logic                                               busy;
  logic                                               done;

  modport master (
    output start, req, llx, lly, trx, try, color,
    input  x, y, pix_color, pix_we, grant, busy, done
  );

  modport slave (
    input  start, req, llx, lly, trx, try, color,
    output x, y, pix_color, pix_we, grant, busy, done
  );
endinterface

// File: rtl/draw_sequencer_rect_scanner.sv
// Column-major rectangle walker: y runs lly..try, then x steps; last flags the final pixel.
module rect_scanner
  import draw_seq_pkg::*;
(
  input  logic               clkf,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  box_t               box,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] x_nxt_c,
  output logic [COORD_W-1:0] y_nxt_c,
  output logic               last_c
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] lly_q, lly_d, trx_q, trx_d, try_q, try_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    lly_d = lly_q;
    trx_d = trx_q;
    try_d = try_q;
    if (load) begin
      x_d   = box.llx;
      y_d   = box.lly;
      lly_d = box.lly;
      trx_d = box.trx;
      try_d = box.try;
    end else if (advance) begin
      if (y_q == try_q) begin
        y_d = lly_q;
        x_d = x_q + COORD_W'(1);
      end else begin
        y_d = y_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clkf) begin
    if (!reset) begin
      x_q   <= '0;
      y_q   <= '0;
      lly_q <= '0;
      trx_q <= '0;
      try_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      lly_q <= lly_d;
      trx_q <= trx_d;
      try_q <= try_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign x_nxt_c = x_d;
  assign y_nxt_c = y_d;
  assign last_c  = (x_q == trx_q) && (y_q == try_q);

endmodule

// File: rtl/draw_sequencer.sv
// Frame scheduler: erases every previously drawn box, then draws the requested boxes in index order.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int unsigned    N_OBJ = 4,
  parameter int unsigned    CW    = 1,
  parameter int unsigned    SCR_W = 640,
  parameter int unsigned    SCR_H = 480,
  parameter logic [CW-1:0]  BG    = '0
) (
  input  logic       clkf,
  input  logic       reset,
  draw_seq_if.slave  bus
);

  localparam int unsigned IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  state_t                   state_q, state_d;
  phase_t                   phase_q, phase_d;
  logic [N_OBJ-1:0]         pend_q, pend_d;
  logic [N_OBJ-1:0]         snap_req_q, snap_req_d;
  logic [N_OBJ-1:0]         old_valid_q, old_valid_d;
  box_t [N_OBJ-1:0]         snap_box_q, snap_box_d;
  box_t [N_OBJ-1:0]         old_box_q, old_box_d;
  logic [N_OBJ-1:0][CW-1:0] snap_col_q, snap_col_d;
  logic [IW-1:0]            cur_q, cur_d;

  logic [CW-1:0]            pix_color_q, pix_color_d;
  logic                     pix_we_q, pix_we_d;
  logic [N_OBJ-1:0]         grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [IW-1:0]            sel_c;
  logic                     any_c;
  box_t                     sel_box_c;
  logic                     load_c, adv_c, last_c;
  logic [COORD_W-1:0]       scan_x, scan_y, x_nxt_c, y_nxt_c;

  // Lowest-index pending object and the box it would use in the current phase.
  always_comb begin
    sel_c = '0;
    any_c = |pend_q;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_c = IW'(i);
    end
    sel_box_c = (phase_q == ERASE) ? old_box_q[sel_c] : snap_box_q[sel_c];
  end

  rect_scanner u_scan (
    .clkf    (clkf),
    .reset   (reset),
    .load    (load_c),
    .advance (adv_c),
    .box     (sel_box_c),
    .x       (scan_x),
    .y       (scan_y),
    .x_nxt_c (x_nxt_c),
    .y_nxt_c (y_nxt_c),
    .last_c  (last_c)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    snap_req_d  = snap_req_q;
    snap_box_d  = snap_box_q;
    snap_col_d  = snap_col_q;
    old_valid_d = old_valid_q;
    old_box_d   = old_box_q;
    cur_d       = cur_q;
    load_c      = 1'b0;
    adv_c       = 1'b0;
    pix_color_d = '0;
    pix_we_d    = 1'b0;
    grant_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_req_d = bus.req;
          snap_col_d = bus.color;
          for (int i = 0; i < N_OBJ; i++) begin
            snap_box_d[i] = '{llx: bus.llx[i], lly: bus.lly[i], trx: bus.trx[i], try: bus.try[i]};
          end
          phase_d = ERASE;
          pend_d  = old_valid_q;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (any_c) begin
          if (box_degenerate(sel_box_c)) begin
            pend_d[sel_c] = 1'b0;
            if (phase_q == DRAW) old_valid_d[sel_c] = 1'b0;
          end else begin
            load_c  = 1'b1;
            cur_d   = sel_c;
            state_d = SCAN;
          end
        end else if (phase_q == ERASE) begin
          // Objects not requested this frame stay erased afterwards.
          phase_d     = DRAW;
          pend_d      = snap_req_q;
          old_valid_d = old_valid_q & snap_req_q;
        end else begin
          state_d = DONE;
        end
      end
      SCAN: begin
        if (last_c) begin
          pend_d[cur_q] = 1'b0;
          if (phase_q == DRAW) begin
            old_box_d[cur_q]   = snap_box_q[cur_q];
            old_valid_d[cur_q] = 1'b1;
          end
          state_d = SELECT;
        end else begin
          adv_c = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == SCAN) begin
      grant_d     = N_OBJ'(1) << cur_d;
      pix_color_d = (phase_q == ERASE) ? BG : snap_col_q[cur_d];
      pix_we_d    = (32'(x_nxt_c) < SCR_W) && (32'(y_nxt_c) < SCR_H);
    end
  end

  always_ff @(posedge clkf) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= ERASE;
      pend_q      <= '0;
      snap_req_q  <= '0;
      snap_box_q  <= '0;
      snap_col_q  <= '0;
      old_valid_q <= '0;
      old_box_q   <= '0;
      cur_q       <= '0;
      pix_color_q <= '0;
      pix_we_q    <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      snap_req_q  <= snap_req_d;
      snap_box_q  <= snap_box_d;
      snap_col_q  <= snap_col_d;
      old_valid_q <= old_valid_d;
      old_box_q   <= old_box_d;
      cur_q       <= cur_d;
      pix_color_q <= pix_color_d;
      pix_we_q    <= pix_we_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.x         = scan_x;
  assign bus.y         = scan_y;
  assign bus.pix_color = pix_color_q;
  assign bus.pix_we    = pix_we_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
